// File: rtl/regbank_pkg.sv
// regbank_pkg: shared state encoding and helpers for the register-bank write path.
package regbank_pkg;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  function automatic int nreg(input int bitAddr);
    return 1 << bitAddr;
  endfunction
  function automatic int sliceBase(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts just after ptr and wraps.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   idx,
  output logic            valid
);
  logic [PW-1:0] k;
  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    idx = '0;
    valid = 1'b0;
    k = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = PW'((int'(ptr) + i) % NREQ);
      if (elig[k]) begin
        idx = k;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: zero-sweeps the bank after reset/clr, then round-robins its write port.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int BIT_ADDR = 4,
  parameter int BIT_DATO = 4,
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BIT_ADDR-1:0] reqAddr,
  input  logic [NREQ*BIT_DATO-1:0] reqDat,
  output logic [NREQ-1:0]          gnt,
  output logic                     RegWrite,
  output logic [BIT_ADDR-1:0]      addrW,
  output logic [BIT_DATO-1:0]      datW,
  output logic                     busy
);
  localparam int NREG = nreg(BIT_ADDR);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [0:0] state;
  logic [BIT_ADDR:0] cnt;
  logic [PW-1:0] ptr, win;
  logic winValid;
  logic [BIT_ADDR-1:0] addrArr [NREQ];
  logic [BIT_DATO-1:0] datArr [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addrArr[g] = reqAddr[sliceBase(g, BIT_ADDR) +: BIT_ADDR];
    assign datArr[g] = reqDat[sliceBase(g, BIT_DATO) +: BIT_DATO];
  end
  // A requester whose grant is showing is not eligible this cycle.
  rr_pick #(.NREQ(NREQ), .PW(PW)) picker (
    .elig(req & ~gnt),
    .ptr(ptr),
    .idx(win),
    .valid(winValid)
  );
  assign busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      ptr <= PW'(NREQ - 1);
      RegWrite <= 1'b0;
      addrW <= '0;
      datW <= '0;
      gnt <= '0;
    end else if (clr) begin
      state <= CLEAR;
      cnt <= (BIT_ADDR + 1)'(1);
      RegWrite <= 1'b1;
      addrW <= '0;
      datW <= '0;
      gnt <= '0;
    end else if (state == CLEAR) begin
      gnt <= '0;
      datW <= '0;
      if (cnt == (BIT_ADDR + 1)'(NREG)) begin
        state <= RUN;
        RegWrite <= 1'b0;
      end else begin
        RegWrite <= 1'b1;
        addrW <= cnt[BIT_ADDR-1:0];
        cnt <= cnt + 1'b1;
      end
    end else begin
      RegWrite <= winValid;
      gnt <= winValid ? NREQ'(1) << win : '0;
      if (winValid) begin
        addrW <= addrArr[win];
        datW <= datArr[win];
        ptr <= win;
      end
    end
  end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: randomized scenarios checked against a cycle-level behavioural model.
module tb_regbank_write_arbiter;
  localparam int BA = 4, BD = 4, NQ = 2, NREG = 16;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [NQ-1:0] req = '0;
  logic [NQ*BA-1:0] reqAddr = '0;
  logic [NQ*BD-1:0] reqDat = '0;
  logic [NQ-1:0] gnt;
  logic RegWrite, busy;
  logic [BA-1:0] addrW;
  logic [BD-1:0] datW;
  int vectors = 0, miscompares = 0;
  logic [BD-1:0] bank [NREG];
  logic [BD-1:0] mBank [NREG];
  int mPhase = 0, mPtr = NQ - 1;
  logic [NQ-1:0] eGnt = '0, prevGnt = '0;
  logic eWr = 1'b0, eBusy = 1'b1;
  logic [BA-1:0] eAddr = '0;
  logic [BD-1:0] eDat = '0;
  int mode [NQ];

  regbank_write_arbiter #(.BIT_ADDR(BA), .BIT_DATO(BD), .NREQ(NQ)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .reqAddr(reqAddr), .reqDat(reqDat),
    .gnt(gnt), .RegWrite(RegWrite), .addrW(addrW), .datW(datW), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic setItem(input int i, input logic [BA-1:0] a, input logic [BD-1:0] d);
    reqAddr[i*BA +: BA] = a;
    reqDat[i*BD +: BD] = d;
    req[i] = 1'b1;
  endtask

  // Model: mPhase>=0 is the next sweep address (NREG = exit cycle), -1 means arbitrating.
  task automatic step();
    logic [NQ-1:0] elig;
    int k;
    bit r;
    r = rst;
    if (rst) begin
      mPhase = 0; mPtr = NQ - 1; eWr = 0; eAddr = '0; eDat = '0; eGnt = '0;
    end else if (clr) begin
      mPhase = 1; eWr = 1; eAddr = '0; eDat = '0; eGnt = '0;
    end else if (mPhase >= 0) begin
      eGnt = '0;
      if (mPhase < NREG) begin
        eWr = 1; eAddr = BA'(mPhase); eDat = '0; mPhase++;
      end else begin
        eWr = 0; mPhase = -1;
      end
    end else begin
      elig = req & ~eGnt;
      k = -1;
      for (int o = 1; o <= NQ; o++)
        if (k < 0 && elig[(mPtr + o) % NQ]) k = (mPtr + o) % NQ;
      eGnt = '0;
      eWr = k >= 0;
      if (k >= 0) begin
        eGnt[k] = 1'b1; eAddr = reqAddr[k*BA +: BA]; eDat = reqDat[k*BD +: BD]; mPtr = k;
      end
    end
    eBusy = mPhase >= 0;
    @(posedge clk);
    #1;
    if (eWr) mBank[eAddr] = eDat;
    if (RegWrite === 1'b1) bank[addrW] = datW;
    for (int i = 0; i < NQ; i++)
      if (!r && prevGnt[i]) begin
        if (mode[i] == 1) req[i] = 1'b0;
        else if (mode[i] == 3) setItem(i, BA'($urandom), BD'($urandom));
      end
    prevGnt = gnt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy} || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL reset c%0d got gnt=%b wr=%b a=%h d=%h busy=%b want %b %b %h %h %b", c, gnt, RegWrite, addrW, datW, busy, eGnt, eWr, eAddr, eDat, eBusy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    int writes = 0;
    for (int c = 0; c < NREG + 1; c++) begin
      step();
      writes += (RegWrite === 1'b1) ? 1 : 0;
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
        miscompares++;
        $display("FAIL sweep c%0d got gnt=%b wr=%b a=%h d=%h busy=%b want %b %b %h %h %b", c, gnt, RegWrite, addrW, datW, busy, eGnt, eWr, eAddr, eDat, eBusy);
      end
    end
    vectors++;
    if (writes != NREG) begin
      miscompares++;
      $display("FAIL sweep_count got %0d writes want %0d", writes, NREG);
    end
    for (int a = 0; a < NREG; a++) begin
      vectors++;
      if (bank[a] !== mBank[a] || bank[a] !== '0) begin
        miscompares++;
        $display("FAIL sweep_bank[%0d] got %h want %h", a, bank[a], mBank[a]);
      end
    end
  endtask

  task automatic test_single();
    int grants = 0;
    mode[0] = 2;
    setItem(0, 4'h5, 4'hA);
    for (int c = 0; c < 8; c++) begin
      step();
      grants += gnt[0] ? 1 : 0;
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
        miscompares++;
        $display("FAIL single c%0d got gnt=%b wr=%b a=%h d=%h busy=%b want %b %b %h %h %b", c, gnt, RegWrite, addrW, datW, busy, eGnt, eWr, eAddr, eDat, eBusy);
      end
    end
    vectors++;
    if (grants != 4) begin
      miscompares++;
      $display("FAIL single_alternate got %0d grants want 4", grants);
    end
    mode[0] = 1;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      grants += (gnt[0] && RegWrite) ? 1 : 0;
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
        miscompares++;
        $display("FAIL single_drop c%0d got gnt=%b wr=%b a=%h d=%h want %b %b %h %h", c, gnt, RegWrite, addrW, datW, eGnt, eWr, eAddr, eDat);
      end
    end
    vectors++;
    if (grants != 1 || bank[5] !== 4'hA) begin
      miscompares++;
      $display("FAIL single_once got %0d writes, reg5=%h want 1 write, reg5=a", grants, bank[5]);
    end
    mode[0] = 0;
    req[0] = 1'b0;
  endtask

  task automatic test_contention();
    logic [NQ-1:0] seen [4];
    test_reset();
    test_sweep();
    mode[0] = 1; mode[1] = 1;
    for (int round = 0; round < 2; round++) begin
      setItem(0, 4'h3, BD'(2 * round + 1));
      setItem(1, 4'h3, BD'(2 * round + 2));
      for (int c = 0; c < 4; c++) begin
        step();
        seen[c] = gnt;
        vectors++;
        if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
          miscompares++;
          $display("FAIL contention r%0d c%0d got gnt=%b wr=%b a=%h d=%h want %b %b %h %h", round, c, gnt, RegWrite, addrW, datW, eGnt, eWr, eAddr, eDat);
        end
      end
      vectors++;
      if (seen[0] !== 2'b01 || seen[1] !== 2'b10 || bank[3] !== BD'(2 * round + 2)) begin
        miscompares++;
        $display("FAIL contention_order r%0d got gnt %b,%b reg3=%h want 01,10 reg3=%h", round, seen[0], seen[1], bank[3], BD'(2 * round + 2));
      end
    end
    mode[0] = 0; mode[1] = 0;
  endtask

  task automatic test_clr_traffic();
    mode[0] = 3; mode[1] = 3;
    setItem(0, BA'($urandom), BD'($urandom));
    setItem(1, BA'($urandom), BD'($urandom));
    for (int c = 0; c < 32; c++) begin
      clr = (c == 6);
      step();
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
        miscompares++;
        $display("FAIL clr_traffic c%0d got gnt=%b wr=%b a=%h d=%h busy=%b want %b %b %h %h %b", c, gnt, RegWrite, addrW, datW, busy, eGnt, eWr, eAddr, eDat, eBusy);
      end
      if (c == 6) begin
        vectors++;
        if (gnt !== '0 || addrW !== '0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL clr_entry got gnt=%b a=%h busy=%b want 00 0 1", gnt, addrW, busy);
        end
      end
    end
    clr = 1'b0;
    mode[0] = 0; mode[1] = 0;
    req = '0;
    step();
    step();
  endtask

  task automatic test_clr_sweep();
    int busyCycles = 0;
    for (int c = 0; c < 28; c++) begin
      clr = (c == 0 || c == 10);
      step();
      busyCycles += (busy === 1'b1) ? 1 : 0;
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
        miscompares++;
        $display("FAIL clr_sweep c%0d got wr=%b a=%h busy=%b want %b %h %b", c, RegWrite, addrW, busy, eWr, eAddr, eBusy);
      end
    end
    clr = 1'b0;
    vectors++;
    if (busyCycles != 26) begin
      miscompares++;
      $display("FAIL clr_sweep_busy got %0d busy cycles want 26", busyCycles);
    end
  endtask

  task automatic test_rst_grant();
    int grants = 0;
    bit seen = 0;
    mode[1] = 1;
    setItem(1, 4'hC, 4'h7);
    for (int c = 0; c < 5 && !seen; c++) begin
      step();
      seen = gnt[1];
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_grant_wait got no gnt[1] within 5 cycles want gnt[1]=1");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy} || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_grant got gnt=%b wr=%b busy=%b want %b %b %b", gnt, RegWrite, busy, eGnt, eWr, eBusy);
    end
    for (int c = 0; c < NREG + 6; c++) begin
      step();
      grants += gnt[1] ? 1 : 0;
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
        miscompares++;
        $display("FAIL rst_after c%0d got gnt=%b wr=%b a=%h d=%h busy=%b want %b %b %h %h %b", c, gnt, RegWrite, addrW, datW, busy, eGnt, eWr, eAddr, eDat, eBusy);
      end
    end
    vectors++;
    if (grants != 1) begin
      miscompares++;
      $display("FAIL rst_served got %0d grants to requester 1 want 1", grants);
    end
    mode[1] = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          mode[i] = $urandom_range(0, 1) ? 3 : 1;
          setItem(i, BA'($urandom), BD'($urandom));
        end
      step();
      vectors++;
      if ({gnt, RegWrite, addrW, datW, busy} !== {eGnt, eWr, eAddr, eDat, eBusy}) begin
        miscompares++;
        $display("FAIL random c%0d got gnt=%b wr=%b a=%h d=%h busy=%b want %b %b %h %h %b", c, gnt, RegWrite, addrW, datW, busy, eGnt, eWr, eAddr, eDat, eBusy);
      end
    end
    clr = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      vectors++;
      if (bank[a] !== mBank[a]) begin
        miscompares++;
        $display("FAIL random_bank[%0d] got %h want %h", a, bank[a], mBank[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < NREG; a++) begin
      bank[a] = BD'($urandom) | 4'h1;
      mBank[a] = bank[a];
    end
    for (int i = 0; i < NQ; i++) mode[i] = 0;
    test_reset();
    test_sweep();
    test_single();
    test_contention();
    test_clr_traffic();
    test_clr_sweep();
    test_rst_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Write-port controller for the team's parameterised register bank: one async-read, clocked-write register file with NREG = 2**BIT_ADDR entries.
- After reset, and on a clear command, sweeps every register to zero.
- Otherwise shares the single write port between NREQ requesters using round-robin arbitration with a req/gnt handshake.
- Drives the bank's write address, write data and write-enable directly from registers.

Parameters:
- BIT_ADDR, 4, register address width; NREG = 2**BIT_ADDR.
- BIT_DATO, 4, data width.
- NREQ, 2, number of write requesters (2..8).

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  one-cycle pulse: start a zero sweep of the bank.
- req  in  NREQ  req[i]=1: requester i wants one write.
- reqAddr  in  NREQ*BIT_ADDR  packed; slice i is requester i's target address.
- reqDat  in  NREQ*BIT_DATO  packed; slice i is requester i's write data.
- gnt  out  NREQ  one-hot, one-cycle grant; high in the same cycle the write is presented to the bank.
- RegWrite  out  1  bank write enable.
- addrW  out  BIT_ADDR  bank write address.
- datW  out  BIT_DATO  bank write data.
- busy  out  1  high while a zero sweep is in progress.

Behaviour:
- Reset and clock: one clock, clk; reset rst is synchronous and active-high.
- Registered outputs: RegWrite, addrW, datW and gnt are all registered; no combinational path from inputs to outputs.
- Reset values (while rst=1): RegWrite=0, addrW=0, datW=0, gnt=0, busy=1. State=CLEAR, sweep counter=0, round-robin pointer=NREQ-1 (requester 0 has first priority).
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle presents RegWrite=1, addrW=counter, datW=0, gnt=0, busy=1; counter increments.
  - The first post-reset edge presents address 0; addresses 0..NREG-1 occupy NREG consecutive cycles.
  - After address NREG-1 is presented, the next cycle has RegWrite=0, busy=0, state=RUN.
  - req is ignored throughout CLEAR.
- RUN:
  - Each cycle, eligible requesters are those with req[i]=1 and gnt[i]=0 in the current cycle. A requester cannot be re-granted while its grant is showing.
  - Search starts at pointer+1 and wraps modulo NREQ; the first eligible index k wins.
  - Next cycle: gnt[k]=1, RegWrite=1, addrW=reqAddr slice k, datW=reqDat slice k (captured at the decision edge); pointer=k.
  - No eligible requester: next cycle RegWrite=0, gnt=0; addrW/datW hold their previous values; pointer unchanged.
- Latency: req rising in cycle t, when eligible and winning, gives gnt and write in cycle t+1. The bank stores the data at the end of t+1.
- Throughput: one write per cycle maximum. A single requester holding req high is granted every other cycle. Two requesters both holding req alternate every cycle.
- Handshake: the requester holds req, address and data stable until it sees gnt. It drops req (or presents the next item) at the edge ending its gnt cycle. req still high the cycle after gnt counts as a new request.
- clr:
  - clr=1 in RUN enters CLEAR with counter=0, overriding any arbitration decision that edge. Next cycle: addrW=0, RegWrite=1, gnt=0, busy=1.
  - clr=1 during CLEAR restarts the sweep at address 0.
  - Pointer is preserved across clr; it is reset only by rst.
- rst mid-sweep or mid-grant: immediate return to reset values. Any pending request is dropped with no grant; the requester keeps req high and is served after the post-reset sweep.
- Simultaneous events: rst beats clr; clr beats req. Two requesters may target the same address; they are serialised in round-robin order and the last grant wins.

Decomposition:
- Shared package regbank_pkg holds:
  - state encoding (CLEAR=0, RUN=1);
  - function nreg(BIT_ADDR) = 2**BIT_ADDR;
  - packed-slice helper functions for reqAddr/reqDat.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: eligible vector and pointer.
  - Outputs: winner index and a valid flag.
  - Reused by future bank arbiters.

Test Plan:
- Post-reset sweep: rst 2 cycles high then low, req=0 -> RegWrite=1 for exactly 16 cycles, addrW 0..15, datW=0, busy=1 throughout; then busy=0, RegWrite=0; bank model all zero.
- Single requester: req[0] held high with addr 5, dat 0xA -> gnt[0] and a write of 0xA to address 5 on alternate cycles only; de-asserting req after the first gnt gives exactly one write.
- Contention: req[0] and req[1] rise in the same cycle, addr 3/dat 0x1 and addr 3/dat 0x2 -> gnt[0] then gnt[1] on consecutive cycles; final register 3 = 0x2; next contention grants requester 0 first again.
- clr mid-traffic: both requesters streaming, clr pulse -> next cycle addrW=0, gnt=0, busy=1; 16-cycle sweep; requests resume round-robin from the preserved pointer; no write lost or duplicated.
- clr during sweep: clr pulse at sweep address 9 -> sweep restarts at 0; busy is high for 10+16 cycles total.
- rst during a grant cycle: rst asserted while gnt[1]=1 -> next cycle gnt=0, RegWrite=0, busy=1; requester 1 still holding req is served once after the sweep.
